// File: rtl/lfsr_checker_if.sv
// lfsr_checker_if: sample and status bundle between an LFSR source and lfsr_checker.
interface lfsr_checker_if #(
    parameter int LEN   = 8,
    parameter int CNT_W = 16
);
    logic             en;
    logic [LEN-1:0]   din;
    logic             clr;
    logic             locked;
    logic             err;
    logic             skip;
    logic [CNT_W-1:0] err_cnt;
    modport master (output en, din, clr, input locked, err, skip, err_cnt);
    modport slave (input en, din, clr, output locked, err, skip, err_cnt);
endinterface

// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising Galois LFSR stream checker with flywheel prediction.
// Define LFSR_CHECKER_SKIP_EN to tolerate single dropped samples while locked.
module lfsr_checker #(
    parameter int             LEN        = 8,
    parameter logic [LEN-1:0] TAPS       = 8'b10111000,
    parameter int             LOCK_CNT   = 4,
    parameter int             UNLOCK_CNT = 3,
    parameter int             CNT_W      = 16
) (
    input logic           clk,
    input logic           rst,
    lfsr_checker_if.slave bus
);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_CNT + 1);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    function automatic logic [LEN-1:0] step(input logic [LEN-1:0] x);
        return {1'b0, x[LEN-1:1]} ^ (x[0] ? TAPS : '0);
    endfunction

    state_t           state_q, state_d;
    logic [LEN-1:0]   pred_q, pred_d, exp_w;
    logic [MW-1:0]    match_q, match_d;
    logic [BW-1:0]    bad_q, bad_d;
    logic             err_q, err_d, skip_q, skip_d, inc;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        exp_w   = step(pred_q);
        state_d = state_q;
        pred_d  = pred_q;
        match_d = match_q;
        bad_d   = bad_q;
        err_d   = 1'b0;
        skip_d  = 1'b0;
        inc     = 1'b0;
        if (bus.en) begin
            case (state_q)
                SEARCH: if (bus.din != '0) begin
                    pred_d  = bus.din;
                    match_d = '0;
                    state_d = VERIFY;
                end
                VERIFY: if (bus.din == '0) begin
                    state_d = SEARCH;
                end else if (bus.din == exp_w) begin
                    pred_d  = bus.din;
                    match_d = match_q + 1'b1;
                    if (match_d == MW'(LOCK_CNT)) begin
                        state_d = LOCKED;
                        bad_d   = '0;
                    end
                end else begin
                    pred_d  = bus.din;
                    match_d = '0;
                end
                default: begin
                    // flywheel: the prediction advances regardless of what was received
                    pred_d = exp_w;
                    if (bus.din == exp_w) begin
                        bad_d = '0;
`ifdef LFSR_CHECKER_SKIP_EN
                    end else if (bus.din == step(exp_w)) begin
                        pred_d = bus.din;
                        skip_d = 1'b1;
                        bad_d  = '0;
`endif
                    end else begin
                        err_d = 1'b1;
                        inc   = 1'b1;
                        bad_d = bad_q + 1'b1;
                        if (bad_d == BW'(UNLOCK_CNT))
                            state_d = SEARCH;
                    end
                end
            endcase
        end
        err_cnt_d = bus.clr ? '0 : (inc && err_cnt_q != '1) ? err_cnt_q + 1'b1 : err_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SEARCH;
            pred_q    <= '1;
            match_q   <= '0;
            bad_q     <= '0;
            err_q     <= 1'b0;
            skip_q    <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pred_q    <= pred_d;
            match_q   <= match_d;
            bad_q     <= bad_d;
            err_q     <= err_d;
            skip_q    <= skip_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.locked  = state_q == LOCKED;
    assign bus.err     = err_q;
    assign bus.skip    = skip_q;
    assign bus.err_cnt = err_cnt_q;
endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: directed scoreboard bench; a 16-bit and a 2-bit counter DUT see identical stimulus.
module tb_lfsr_checker;
    typedef struct {
        logic        l;
        logic        e;
        logic        s;
        logic [15:0] c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pend = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    lfsr_checker_if #(.LEN(8), .CNT_W(16)) bus ();
    lfsr_checker_if #(.LEN(8), .CNT_W(2))  sif ();

    assign sif.en  = bus.en;
    assign sif.din = bus.din;
    assign sif.clr = bus.clr;

    lfsr_checker #(.LEN(8), .TAPS(8'b10111000), .LOCK_CNT(4), .UNLOCK_CNT(3), .CNT_W(16))
        dut (.clk(clk), .rst(rst), .bus(bus));
    lfsr_checker #(.LEN(8), .TAPS(8'b10111000), .LOCK_CNT(4), .UNLOCK_CNT(3), .CNT_W(2))
        dut_sat (.clk(clk), .rst(rst), .bus(sif));

    function void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    always @(posedge clk) pend <= bus.en && !rst;

    always @(negedge clk) begin
        exp_t item;
        if (pend) begin
            if (q.size() == 0) begin
                chk("unexpected_response", 16'd1, 16'd0);
            end else begin
                item = q.pop_front();
                chk("locked", 16'(bus.locked), 16'(item.l));
                chk("err", 16'(bus.err), 16'(item.e));
                chk("skip", 16'(bus.skip), 16'(item.s));
                chk("err_cnt", bus.err_cnt, item.c);
                chk("sat_cnt", 16'(sif.err_cnt), item.c > 16'd3 ? 16'd3 : item.c);
            end
        end else begin
            chk("idle_err", 16'(bus.err), 16'd0);
            chk("idle_skip", 16'(bus.skip), 16'd0);
        end
    end

    task automatic send(input logic [7:0] d, input logic c, input logic l, input logic e,
                        input logic s, input logic [15:0] n);
        @(negedge clk);
        bus.en  = 1'b1;
        bus.din = d;
        bus.clr = c;
        q.push_back('{l, e, s, n});
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            bus.en  = 1'b0;
            bus.clr = 1'b0;
        end
    endtask

    task automatic clear();
        @(negedge clk);
        bus.en  = 1'b0;
        bus.clr = 1'b1;
    endtask

    // reset with a concurrent en that must be ignored
    task automatic do_rst();
        @(negedge clk);
        rst     = 1'b1;
        bus.en  = 1'b1;
        bus.din = 8'hDB;
        bus.clr = 1'b0;
        @(negedge clk);
        rst    = 1'b0;
        bus.en = 1'b0;
        chk("rst_locked", 16'(bus.locked), 16'd0);
        chk("rst_err_cnt", bus.err_cnt, 16'd0);
        chk("rst_err", 16'(bus.err), 16'd0);
        chk("rst_skip", 16'(bus.skip), 16'd0);
    endtask

    task automatic lock_seq(input bit gap, input logic [15:0] n);
        logic [7:0] w [5] = '{8'hFF, 8'hC7, 8'hDB, 8'hD5, 8'hD2};
        for (int i = 0; i < 5; i++) begin
            send(w[i], 1'b0, i == 4, 1'b0, 1'b0, n);
            if (gap) idle(1);
        end
    endtask

    initial begin
        bus.en  = 1'b0;
        bus.din = 8'h00;
        bus.clr = 1'b0;
        repeat (3) @(negedge clk);
        do_rst();
        lock_seq(1'b0, 16'd0);
        idle(1);
        send(8'h69, 0, 1, 0, 0, 16'd0);
        send(8'h0C, 0, 1, 1, 0, 16'd1);
        send(8'h46, 0, 1, 0, 0, 16'd1);
        send(8'h23, 0, 1, 0, 0, 16'd1);
        idle(1);
        clear();
        send(8'h00, 0, 1, 1, 0, 16'd1);
        send(8'h00, 0, 1, 1, 0, 16'd2);
        send(8'h00, 0, 0, 1, 0, 16'd3);
        lock_seq(1'b0, 16'd3);
        idle(1);
        // clear beats a simultaneous error; flywheel keeps the prediction on 8C
        send(8'h00, 1, 1, 1, 0, 16'd0);
        send(8'h8C, 0, 1, 0, 0, 16'd0);
        send(8'h00, 0, 1, 1, 0, 16'd1);
        send(8'h23, 0, 1, 0, 0, 16'd1);
        send(8'h00, 0, 1, 1, 0, 16'd2);
        send(8'hEC, 0, 1, 0, 0, 16'd2);
        send(8'h00, 0, 1, 1, 0, 16'd3);
        send(8'h3B, 0, 1, 0, 0, 16'd3);
        send(8'h00, 0, 1, 1, 0, 16'd4);
        send(8'hEA, 0, 1, 0, 0, 16'd4);
        send(8'h00, 0, 1, 1, 0, 16'd5);
        idle(1);
        do_rst();
        lock_seq(1'b1, 16'd0);
        idle(1);
        do_rst();
        send(8'hFF, 0, 0, 0, 0, 16'd0);
        send(8'hC7, 0, 0, 0, 0, 16'd0);
        do_rst();
        send(8'hDB, 0, 0, 0, 0, 16'd0);
        send(8'hD5, 0, 0, 0, 0, 16'd0);
        send(8'hD2, 0, 0, 0, 0, 16'd0);
        send(8'h69, 0, 0, 0, 0, 16'd0);
        send(8'h8C, 0, 1, 0, 0, 16'd0);
        idle(1);
        do_rst();
        send(8'hFF, 0, 0, 0, 0, 16'd0);
        send(8'h00, 0, 0, 0, 0, 16'd0);
        send(8'hC7, 0, 0, 0, 0, 16'd0);
        send(8'hDB, 0, 0, 0, 0, 16'd0);
        send(8'hD5, 0, 0, 0, 0, 16'd0);
        send(8'hD2, 0, 0, 0, 0, 16'd0);
        send(8'h69, 0, 1, 0, 0, 16'd0);
        idle(1);
        do_rst();
        send(8'h8F, 0, 0, 0, 0, 16'd0);
        send(8'hFF, 0, 0, 0, 0, 16'd0);
        send(8'hC7, 0, 0, 0, 0, 16'd0);
        send(8'hDB, 0, 0, 0, 0, 16'd0);
        send(8'hD5, 0, 1, 0, 0, 16'd0);
`ifdef LFSR_CHECKER_SKIP_EN
        send(8'h69, 0, 1, 0, 1, 16'd0);
        send(8'h8C, 0, 1, 0, 0, 16'd0);
`else
        send(8'h69, 0, 1, 1, 0, 16'd1);
        send(8'h69, 0, 1, 0, 0, 16'd1);
`endif
        idle(2);
        chk("drain", 16'(q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Receive-side companion to the team's Galois LFSR generator.
- Each cycle `en` is high, it samples the generator's parallel state word, self-synchronises to it, then predicts every following word using its own free-running copy of the LFSR (a flywheel).
- Reports lock status, per-sample mismatch pulses and a saturating error count.
- Used on Nexys7 to validate random-number streams and link/loopback paths, and in self-test.

Parameters:
- LEN, 8, width of the LFSR word.
- TAPS, 8'b10111000, XOR tap mask; must match the generator.
- LOCK_CNT, 4, consecutive correct predictions needed to declare lock (≥1).
- UNLOCK_CNT, 3, consecutive mispredictions while locked that force resync (≥1).
- CNT_W, 16, width of the error counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  sample valid; `din` is evaluated only when high.
- din  in  LEN  observed LFSR word.
- clr  in  1  synchronous clear of `err_cnt`.
- locked  out  1  high while in LOCKED.
- err  out  1  one-cycle pulse per mispredicted sample while locked.
- skip  out  1  one-cycle pulse per tolerated dropped sample; tied 0 without the optional feature.
- err_cnt  out  CNT_W  saturating mismatch count.

Behaviour:
- Step function: next(x) = {1'b0, x[LEN-1:1]} ^ (x[0] ? TAPS : 0). This is bit-identical to the generator's update.
- All outputs are registered. A response appears the cycle after the `en` cycle that caused it. With `en` low, all state holds and the pulses are 0.
- Reset:
  - state = SEARCH, `pred` = all ones, match/bad run counters = 0.
  - `locked` = 0, `err` = 0, `skip` = 0, `err_cnt` = 0.
  - `rst` mid-operation aborts any state immediately; a concurrent `en` is ignored.
- SEARCH, on `en`:
  - `din` == 0 (illegal LFSR state): stay in SEARCH.
  - Otherwise: `pred` <= `din`, match counter <= 0, go to VERIFY.
- VERIFY, on `en`:
  - `din` == next(`pred`): `pred` <= `din`, match counter +1. When the count reaches LOCK_CNT, go to LOCKED; `locked` rises the next cycle.
  - `din` ≠ next(`pred`) and `din` ≠ 0: reseed (`pred` <= `din`, match counter <= 0), stay in VERIFY.
  - `din` == 0: go to SEARCH.
  - No `err` pulses and no counting in SEARCH or VERIFY.
- LOCKED, on `en`, with exp = next(`pred`):
  - `pred` <= exp always (flywheel), so a corrupted `din` never corrupts the prediction.
  - `din` == exp: bad run counter <= 0.
  - Otherwise: `err` pulse, `err_cnt` +1 saturating at all ones, bad run counter +1. When the bad run reaches UNLOCK_CNT, go to SEARCH and `locked` falls the next cycle. The sample that triggers unlock is still counted as an error.
- `clr` has priority over a simultaneous increment: `err_cnt` = 0 next cycle and that error is not counted. `clr` does not affect state or lock.
- At saturation, further errors still pulse `err`; the count holds.

Optional Feature:
- Macro: LFSR_CHECKER_SKIP_EN.
- Defined: in LOCKED, if `din` ≠ exp but `din` == next(exp), treat it as one dropped sample:
  - `pred` <= `din`, `skip` pulse, bad run counter <= 0.
  - No `err` pulse and no count.
- Undefined: this case is an ordinary mismatch and `skip` is constant 0.

Test Plan:
- Lock-in: rst, then `en` with `din` = FF, C7, DB, D5, D2 → `locked` = 1 the cycle after D2; `err` never pulses; `err_cnt` = 0.
- Single bit error: locked at D2, feed 69, 0C (expected 8C), 46 → exactly one `err` pulse, aligned to 0C; `err_cnt` = 1; `locked` stays 1; next expected after 46 is 23.
- Unlock: locked, then feed 3 consecutive wrong words (00, 00, 00) → `err` ×3, `err_cnt` = 3, `locked` = 0 after the third; a following FF, C7, DB, D5, D2 relocks.
- Gaps and clear:
  - Lock with `en` toggling every other cycle → identical result to the lock-in test.
  - `clr` asserted in the same cycle as an error → `err_cnt` = 0.
  - CNT_W = 2, 5 errors → `err_cnt` holds at 3.
- Reset mid-VERIFY: after FF, C7, assert rst → `locked` = 0 and state = SEARCH; the next 4-match sequence is required before `locked` rises.
- Skip (macro defined): locked at D5, feed 69 (D2 dropped) → `skip` pulse, no `err`, next expected 8C. Macro undefined: the same stimulus → `err` pulse; with the flywheel, next expected is 69.
